// File: rtl/led_rate_meas.sv
// led_rate_meas: measures the clock-cycle spacing between consecutive toggles
// of an asynchronous input and recovers the blink divisor as CNT_1S / (h - 1).
//
// Ports:
//   clk100    system clock
//   rst       synchronous active-high reset
//   led_i     asynchronous toggling input under measurement
//   en_i      measurement enable; low returns to ARM and clears the counter
//   period_o  last captured half-period in cycles
//   div_o     recovered divisor, saturated to 31
//   valid_o   one-cycle pulse when period_o/div_o update
//   busy_o    high while the divider iterates
//   timeout_o sticky no-edge flag; cleared by rst, en_i low or the next valid_o
//
// Optional feature: define LED_RATE_MEAS_GLITCH_FILT_EN to insert a stability
// filter (FILT_LEN equal samples) between the synchronizer and edge detection.

module led_rate_meas #(
  parameter logic [27:0] CNT_1S      = 28'h5F5E100,
  parameter logic [27:0] TIMEOUT_CYC = 28'hBEBC200,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        led_i,
  input  logic        en_i,
  output logic [27:0] period_o,
  output logic [4:0]  div_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned CW = 28;
  localparam int unsigned IW = 5;
  localparam int unsigned DW = 5;
  localparam logic [IW-1:0] LAST_ITER = IW'(CW - 1);
  localparam logic [CW-1:0] DIV_MAX   = CW'((1 << DW) - 1);

  // Elaboration-time parameter legality check.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1) begin : g_bad_param
    $error("led_rate_meas: SYNC_STAGES must be 2..4 and FILT_LEN >= 1");
  end

  typedef enum logic [1:0] {ARM, MEAS, DIVIDE, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   level;
  logic                   level_q;
  logic                   edge_det;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cap;
  logic [CW-1:0]          dvsr;
  logic [CW-1:0]          rem;
  logic [CW-1:0]          quo;
  logic [IW-1:0]          idx;
  logic [CW:0]            rem_sh;
  logic                   take;
  logic [CW-1:0]          rem_nxt;

  // Input synchronizer.
  always_ff @(posedge clk100) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], led_i};
    end
  end

`ifdef LED_RATE_MEAS_GLITCH_FILT_EN
  localparam int unsigned FW = $clog2(FILT_LEN + 1);

  logic          filt_level;
  logic [FW-1:0] filt_cnt;

  // Level follows the synchronized input only after FILT_LEN consecutive
  // samples that disagree with it; shorter pulses reset the run count.
  always_ff @(posedge clk100) begin
    if (rst) begin
      filt_level <= 1'b0;
      filt_cnt   <= '0;
    end else if (sync[SYNC_STAGES-1] == filt_level) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      filt_level <= sync[SYNC_STAGES-1];
      filt_cnt   <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign level = filt_level;
`else
  assign level = sync[SYNC_STAGES-1];
`endif

  // Any transition of the (optionally filtered) level is an edge.
  assign edge_det = level ^ level_q;

  // One restoring-division step: shift in the next numerator bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem, quo[CW-1]};
    take    = (rem_sh >= {1'b0, dvsr});
    rem_nxt = take ? CW'(rem_sh - {1'b0, dvsr}) : rem_sh[CW-1:0];
  end

  // Edge counter, measurement FSM and divider.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state     <= ARM;
      level_q   <= 1'b0;
      cnt       <= '0;
      cap       <= '0;
      dvsr      <= '0;
      rem       <= '0;
      quo       <= '0;
      idx       <= '0;
      period_o  <= '0;
      div_o     <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      level_q <= level;
      valid_o <= 1'b0;
      if (!en_i) begin
        // Abort: results keep their last values, no valid pulse.
        state     <= ARM;
        cnt       <= '0;
        busy_o    <= 1'b0;
        timeout_o <= 1'b0;
      end else begin
        if (edge_det) begin
          cnt <= CW'(1);
        end else if (cnt < TIMEOUT_CYC) begin
          cnt <= cnt + 1'b1;
        end

        case (state)
          ARM: begin
            if (edge_det) begin
              state <= MEAS;
            end
          end
          MEAS: begin
            // An edge coinciding with the timeout count wins.
            if (edge_det) begin
              cap    <= cnt;
              dvsr   <= cnt - 1'b1;
              rem    <= '0;
              quo    <= CNT_1S;
              idx    <= '0;
              busy_o <= 1'b1;
              state  <= DIVIDE;
            end else if (cnt >= TIMEOUT_CYC) begin
              timeout_o <= 1'b1;
              state     <= ARM;
            end
          end
          DIVIDE: begin
            rem <= rem_nxt;
            quo <= {quo[CW-2:0], take};
            idx <= idx + 1'b1;
            if (idx == LAST_ITER) begin
              busy_o <= 1'b0;
              state  <= DONE;
            end
          end
          DONE: begin
            period_o <= cap;
            if (dvsr == '0 || quo > DIV_MAX) begin
              div_o <= '1;
            end else begin
              div_o <= quo[DW-1:0];
            end
            valid_o   <= 1'b1;
            timeout_o <= 1'b0;
            state     <= MEAS;
          end
          default: begin
            state <= ARM;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_rate_meas.sv
// Testbench for led_rate_meas (CNT_1S = 1000, TIMEOUT_CYC = 2000, SYNC_STAGES = 2).
// The reference model works on led_i toggle times: an edge is captured when the
// measurement is armed, lies within the timeout of the previous edge and falls at
// least 30 cycles after the previous capture; the expected result is the spacing
// to the previous edge and min(1000 / (spacing - 1), 31).

module tb_led_rate_meas;

  localparam int NUM  = 1000;
  localparam int TMO  = 2000;
  localparam int SYNC = 2;
  localparam int SKIP = 30;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        led_i;
  logic        en_i;
  logic [27:0] period_o;
  logic [4:0]  div_o;
  logic        valid_o;
  logic        busy_o;
  logic        timeout_o;

  always #5 clk100 = ~clk100;

  led_rate_meas #(
    .CNT_1S      (28'd1000),
    .TIMEOUT_CYC (28'd2000),
    .SYNC_STAGES (2),
    .FILT_LEN    (4)
  ) dut (
    .clk100    (clk100),
    .rst       (rst),
    .led_i     (led_i),
    .en_i      (en_i),
    .period_o  (period_o),
    .div_o     (div_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  typedef struct {
    int per;
    int dv;
    int tmo;
  } res_t;

  res_t obs_q[$];
  res_t exp_q[$];
  int   vcyc_q[$];
  int   busy_runs[$];
  int   busy_run  = 0;
  int   cyc       = 0;
  int   last_edge = 0;
  int   last_cap  = 0;
  bit   active    = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  function automatic int exp_div(int h);
    int q;
    if (h <= 1) return 31;
    q = NUM / (h - 1);
    return (q > 31) ? 31 : q;
  endfunction

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic step();
    res_t r;
    @(posedge clk100);
    #1;
    cyc++;
    if (valid_o) begin
      r.per = 32'(period_o);
      r.dv  = 32'(div_o);
      r.tmo = 32'(timeout_o);
      obs_q.push_back(r);
      vcyc_q.push_back(cyc);
    end
    if (busy_o) begin
      busy_run++;
    end else if (busy_run != 0) begin
      busy_runs.push_back(busy_run);
      busy_run = 0;
    end
  endtask

  task automatic wait_cycles(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic edge_model();
    res_t r;
    int   sp;
    sp = cyc - last_edge;
    if (!active || sp > TMO) begin
      active   = 1'b1;
      last_cap = cyc - 1000;
    end else if (cyc - last_cap >= SKIP) begin
      r.per = sp;
      r.dv  = exp_div(sp);
      r.tmo = 0;
      exp_q.push_back(r);
      last_cap = cyc;
    end
    last_edge = cyc;
  endtask

  task automatic toggle();
    led_i = ~led_i;
    edge_model();
  endtask

  // Short pulse edge: invisible to the model when the glitch filter is built in.
  task automatic glitch_flip();
`ifdef LED_RATE_MEAS_GLITCH_FILT_EN
    led_i = ~led_i;
`else
    toggle();
`endif
  endtask

  task automatic toggle_every(int sp, int n);
    for (int i = 0; i < n; i++) begin
      toggle();
      wait_cycles(sp);
    end
  endtask

  task automatic compare_results(string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_period"}, obs_q[i].per, exp_q[i].per);
      chk({tag, "_div"}, obs_q[i].dv, exp_q[i].dv);
      chk({tag, "_tmo_at_valid"}, obs_q[i].tmo, 0);
    end
    obs_q.delete();
    exp_q.delete();
    vcyc_q.delete();
  endtask

  task automatic check_busy(string tag);
    chk({tag, "_busy_seen"}, (busy_runs.size() > 0) ? 1 : 0, 1);
    for (int i = 0; i < busy_runs.size(); i++) begin
      chk({tag, "_busy_len"}, busy_runs[i], 28);
    end
    busy_runs.delete();
  endtask

  initial begin
    int t0;
    int rise;
    int seen;
    int min_per;
    int sp;
    int dir_sp[7] = '{40, 29, 40, 30, 40, 31, 40};

    rst   = 1'b1;
    en_i  = 1'b1;
    led_i = 1'b0;

    // Reset held while led_i toggles.
    for (int i = 0; i < 5; i++) begin
      led_i = ~led_i;
      step();
      chk("rst_outputs", {period_o, div_o, valid_o, busy_o, timeout_o}, 0);
    end
    led_i = 1'b0;
    rst   = 1'b0;
    step();
    chk("post_rst_outputs", {period_o, div_o, valid_o, busy_o, timeout_o}, 0);
    active = 1'b0;
    obs_q.delete();
    vcyc_q.delete();
    busy_runs.delete();

    // Nominal rate: one edge alone yields nothing, then spacing 251.
    toggle();
    wait_cycles(251);
    chk("one_edge_no_valid", obs_q.size(), 0);
    toggle_every(251, 5);
    for (int i = 1; i < vcyc_q.size(); i++) begin
      chk("nominal_valid_spacing", vcyc_q[i] - vcyc_q[i-1], 251);
    end
    compare_results("nominal");
    check_busy("nominal");

    // Saturation: fast toggles (div 31), slow toggles (div 0), edge at timeout count.
    toggle_every(21, 12);
    toggle_every(1500, 3);
    toggle_every(2000, 2);
    chk("edge_wins_no_timeout", timeout_o, 0);
    compare_results("sat");
    busy_runs.delete();

    // Timeout: static input after an edge, then resume at spacing 101.
    toggle();
    t0   = cyc;
    rise = -1;
    for (int i = 0; i < 2500; i++) begin
      step();
      if (timeout_o && rise < 0) rise = cyc - t0;
    end
    chk("tmo_delay", rise, TMO + SYNC + 1);
    chk("tmo_sticky", timeout_o, 1);
    toggle();
    wait_cycles(101);
    chk("tmo_sticky_after_arm", timeout_o, 1);
    toggle_every(101, 4);
    chk("tmo_cleared", timeout_o, 0);
    compare_results("timeout");
    busy_runs.delete();

    // Abort: drop en_i 10 cycles into the divide.
    wait_cycles(60);
    toggle();
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      if (busy_o) seen = 1;
    end
    chk("abort_busy_start", seen, 1);
    wait_cycles(9);
    en_i = 1'b0;
    step();
    chk("abort_busy_low", busy_o, 0);
    chk("abort_tmo_low", timeout_o, 0);
    void'(exp_q.pop_back());
    active = 1'b0;
    wait_cycles(60);
    chk("abort_no_valid", obs_q.size(), 0);
    chk("abort_period_kept", period_o, 101);
    chk("abort_div_kept", div_o, 10);
    busy_runs.delete();

    // Re-enable: two edges needed before a capture.
    en_i = 1'b1;
    wait_cycles(5);
    toggle();
    wait_cycles(101);
    chk("reen_one_edge_no_valid", obs_q.size(), 0);
    toggle_every(77, 4);
    compare_results("reen");
    check_busy("reen");

    // Spacings around the 30-cycle capture window.
    for (int i = 0; i < 7; i++) begin
      toggle();
      wait_cycles(dir_sp[i]);
    end
    wait_cycles(40);
    compare_results("window");

    // Randomized spacings, mostly inside the timeout.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) sp = int'($urandom_range(8, 40));
      else sp = int'($urandom_range(41, 1999));
      toggle();
      wait_cycles(sp);
    end
    wait_cycles(40);
    compare_results("rand");
    busy_runs.delete();

    // Glitch: 2-cycle pulse in the middle of a 251-cycle interval.
    toggle();
    wait_cycles(251);
    toggle();
    wait_cycles(40);
    compare_results("pre_glitch");
    wait_cycles(211);
    toggle();
    wait_cycles(120);
    glitch_flip();
    wait_cycles(2);
    glitch_flip();
    wait_cycles(129);
    toggle();
    wait_cycles(251);
    toggle();
    wait_cycles(40);
    min_per = 1 << 30;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].per < min_per) min_per = obs_q[i].per;
    end
`ifdef LED_RATE_MEAS_GLITCH_FILT_EN
    chk("glitch_filtered_min_period", min_per, 251);
`else
    chk("glitch_short_period_seen", (min_per < 251) ? 1 : 0, 1);
`endif
    compare_results("glitch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
